// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction/pc widths and the instruction-queue entry layout.
package cpu_pkg;
    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } iq_entry_t;
endpackage

// File: rtl/iq_fifo_mem.sv
// Instruction-queue storage: DEPTH entries, synchronous write, asynchronous read at the head pointer.
module iq_fifo_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_in,
    input  logic              wr_en_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  iq_entry_t         wr_data_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output iq_entry_t         rd_data_out
);

    // Contents are never reset; occupancy is tracked by the owning queue.
    iq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
    end

    assign rd_data_out = mem_q[rd_addr_in];

endmodule

// File: rtl/instruction_queue.sv
// In-order fetch-to-ROB instruction FIFO with a registered issue port and flush.
// Optional macro IQ_BYPASS_EN: an instruction arriving at an empty queue with the ROB ready issues on the same edge.
module instruction_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              fetch_valid_in,
    input  logic [INST_W-1:0] fetch_inst_in,
    input  logic [PC_W-1:0]   fetch_pc_in,
    output logic              iq_full_out,
    input  logic              rob_full_in,
    output logic              issue_valid_out,
    output logic [INST_W-1:0] issue_inst_out,
    output logic [PC_W-1:0]   issue_pc_out
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              issue_valid_q, issue_valid_d;
    iq_entry_t         issue_q, issue_d;

    iq_entry_t fetch_entry;
    iq_entry_t rd_data;
    logic      full;
    logic      enq;
    logic      deq;
    logic      bypass;
    logic      wr_en;

    assign fetch_entry.inst = fetch_inst_in;
    assign fetch_entry.pc   = fetch_pc_in;

    // Full and empty are judged on the pre-edge count, so a same-edge dequeue never frees a slot.
    assign full = (count_q == DEPTH_CNT);
    assign enq  = fetch_valid_in & ~full;
    assign deq  = (count_q != '0) & ~rob_full_in;

`ifdef IQ_BYPASS_EN
    assign bypass = (count_q == '0) & enq & ~rob_full_in;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        issue_valid_d = issue_valid_q;
        issue_d       = issue_q;
        wr_en         = 1'b0;
        if (rdy_in) begin
            if (flush_in) begin
                head_d        = '0;
                tail_d        = '0;
                count_d       = '0;
                issue_valid_d = 1'b0;
            end else if (bypass) begin
                issue_d       = fetch_entry;
                issue_valid_d = 1'b1;
            end else begin
                wr_en = enq;
                if (enq) begin
                    tail_d = tail_q + 1'b1;
                end
                // Without a dequeue the data registers keep their last value; only valid drops.
                if (deq) begin
                    issue_d       = rd_data;
                    head_d        = head_q + 1'b1;
                    issue_valid_d = 1'b1;
                end else begin
                    issue_valid_d = 1'b0;
                end
                count_d = count_q + (ADDR_W+1)'(enq) - (ADDR_W+1)'(deq);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_q       <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_q       <= issue_d;
        end
    end

    iq_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_in      (clk_in),
        .wr_en_in    (wr_en),
        .wr_addr_in  (tail_q),
        .wr_data_in  (fetch_entry),
        .rd_addr_in  (head_q),
        .rd_data_out (rd_data)
    );

    assign iq_full_out     = full;
    assign issue_valid_out = issue_valid_q;
    assign issue_inst_out  = issue_q.inst;
    assign issue_pc_out    = issue_q.pc;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: queue-based reference model checked every cycle plus literal spot checks.
module tb_instruction_queue;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic        fetch_valid_in;
    logic [31:0] fetch_inst_in;
    logic [31:0] fetch_pc_in;
    logic        iq_full_out;
    logic        rob_full_in;
    logic        issue_valid_out;
    logic [31:0] issue_inst_out;
    logic [31:0] issue_pc_out;

    int n_checks = 0;
    int n_errors = 0;

    instruction_queue #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .rdy_in          (rdy_in),
        .flush_in        (flush_in),
        .fetch_valid_in  (fetch_valid_in),
        .fetch_inst_in   (fetch_inst_in),
        .fetch_pc_in     (fetch_pc_in),
        .iq_full_out     (iq_full_out),
        .rob_full_in     (rob_full_in),
        .issue_valid_out (issue_valid_out),
        .issue_inst_out  (issue_inst_out),
        .issue_pc_out    (issue_pc_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of {inst,pc} plus the expected issue registers.
    logic [63:0] mq[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_inst  = '0;
    logic [31:0] m_pc    = '0;

    initial begin
        forever begin
            @(posedge clk_in or negedge rst_n_in);
            if (!rst_n_in) begin
                mq.delete();
                m_valid = 1'b0;
                m_inst  = '0;
                m_pc    = '0;
            end else if (rdy_in) begin
                if (flush_in) begin
                    mq.delete();
                    m_valid = 1'b0;
                end else begin
                    automatic bit was_empty = (mq.size() == 0);
                    automatic bit take = fetch_valid_in && (mq.size() < 16);
                    automatic logic [63:0] e;
`ifdef IQ_BYPASS_EN
                    if (was_empty && take && !rob_full_in) begin
                        m_valid = 1'b1;
                        m_inst  = fetch_inst_in;
                        m_pc    = fetch_pc_in;
                        take    = 1'b0;
                    end else
`endif
                    if (!was_empty && !rob_full_in) begin
                        e = mq.pop_front();
                        m_valid = 1'b1;
                        m_inst  = e[63:32];
                        m_pc    = e[31:0];
                    end else begin
                        m_valid = 1'b0;
                    end
                    if (take) mq.push_back({fetch_inst_in, fetch_pc_in});
                end
            end
        end
    end

    always @(negedge clk_in) begin
        chk("model_valid", {31'b0, issue_valid_out}, {31'b0, m_valid});
        chk("model_inst",  issue_inst_out, m_inst);
        chk("model_pc",    issue_pc_out,   m_pc);
        chk("model_full",  {31'b0, iq_full_out}, {31'b0, mq.size() == 16});
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        fetch_valid_in = 1'b1;
        fetch_pc_in    = pc;
        fetch_inst_in  = 32'hC000_0000 | pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded limit %0d", $time, 100000);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in       = 1'b0;
        rdy_in         = 1'b1;
        flush_in       = 1'b0;
        fetch_valid_in = 1'b0;
        fetch_inst_in  = '0;
        fetch_pc_in    = '0;
        rob_full_in    = 1'b1;
        #1;
        chk("reset_valid", {31'b0, issue_valid_out}, 32'd0);
        chk("reset_pc",    issue_pc_out, 32'd0);
        chk("reset_full",  {31'b0, iq_full_out}, 32'd0);
        repeat (2) step();
        rst_n_in = 1'b1;
        step();

        // 1: reset in the middle of a stream
        rob_full_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(32'h10 + 32'(i) * 4);
            step();
        end
        fetch_valid_in = 1'b0;
        chk("t1_pre_valid", {31'b0, issue_valid_out}, 32'd1);
        #2 rst_n_in = 1'b0;
        #1;
        chk("t1_async_valid", {31'b0, issue_valid_out}, 32'd0);
        chk("t1_async_pc",    issue_pc_out, 32'd0);
        chk("t1_async_inst",  issue_inst_out, 32'd0);
        step();
        rst_n_in = 1'b1;
        repeat (3) step();
        chk("t1_no_issue", {31'b0, issue_valid_out}, 32'd0);

        // 2: fill to full, refuse the 17th, drain in order
        rob_full_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            offer(32'(i) * 4);
            step();
        end
        chk("t2_full", {31'b0, iq_full_out}, 32'd1);
        offer(32'h40);
        step();
        fetch_valid_in = 1'b0;
        rob_full_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t2_drain_valid", {31'b0, issue_valid_out}, 32'd1);
            chk("t2_drain_pc",    issue_pc_out, 32'(i) * 4);
        end
        step();
        chk("t2_refused_not_issued", {31'b0, issue_valid_out}, 32'd0);

        // 3: full with simultaneous issue and push
        rob_full_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            offer(32'h300 + 32'(i) * 4);
            step();
        end
        rob_full_in = 1'b0;
        offer(32'h400);
        step();
        chk("t3_issue_pc", issue_pc_out, 32'h300);
        chk("t3_not_full", {31'b0, iq_full_out}, 32'd0);
        step();
        chk("t3_second_pc", issue_pc_out, 32'h304);
        fetch_valid_in = 1'b0;
        repeat (14) step();
        chk("t3_mid_pc", issue_pc_out, 32'h33C);
        step();
        chk("t3_late_push_pc", issue_pc_out, 32'h400);
        step();
        chk("t3_empty", {31'b0, issue_valid_out}, 32'd0);

        // 4: flush with a same-edge fetch
        rob_full_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            offer(32'h500 + 32'(i) * 4);
            step();
        end
        rob_full_in = 1'b0;
        flush_in = 1'b1;
        offer(32'h600);
        step();
        flush_in = 1'b0;
        fetch_valid_in = 1'b0;
        chk("t4_flush_valid", {31'b0, issue_valid_out}, 32'd0);
        offer(32'h100);
        step();
        fetch_valid_in = 1'b0;
`ifndef IQ_BYPASS_EN
        step();
`endif
        chk("t4_next_valid", {31'b0, issue_valid_out}, 32'd1);
        chk("t4_next_pc",    issue_pc_out, 32'h100);
        step();
        chk("t4_drained", {31'b0, issue_valid_out}, 32'd0);

        // 5: pause freezes everything, including an offered fetch
        rob_full_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(32'h700 + 32'(i) * 4);
            step();
        end
        fetch_valid_in = 1'b0;
        rob_full_in = 1'b0;
        step();
        chk("t5_first_pc", issue_pc_out, 32'h700);
        rdy_in = 1'b0;
        offer(32'h7F0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_frozen_valid", {31'b0, issue_valid_out}, 32'd1);
            chk("t5_frozen_pc",    issue_pc_out, 32'h700);
        end
        fetch_valid_in = 1'b0;
        rdy_in = 1'b1;
        step();
        chk("t5_resume_pc1", issue_pc_out, 32'h704);
        step();
        chk("t5_resume_pc2", issue_pc_out, 32'h708);
        step();
        chk("t5_idle", {31'b0, issue_valid_out}, 32'd0);

        // 6: latency from an empty queue
        offer(32'h200);
        step();
        fetch_valid_in = 1'b0;
`ifdef IQ_BYPASS_EN
        chk("t6_after_n_valid", {31'b0, issue_valid_out}, 32'd1);
        chk("t6_after_n_pc",    issue_pc_out, 32'h200);
`else
        chk("t6_after_n_valid", {31'b0, issue_valid_out}, 32'd0);
        step();
        chk("t6_after_n1_valid", {31'b0, issue_valid_out}, 32'd1);
        chk("t6_after_n1_pc",    issue_pc_out, 32'h200);
        chk("t6_after_n1_inst",  issue_inst_out, 32'hC000_0200);
`endif
        step();
        chk("t6_single_cycle", {31'b0, issue_valid_out}, 32'd0);

        @(posedge clk_in);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
